// File: rtl/ppu_arb_pkg.sv
// Shared types and constants for the PPU request arbiter.
package ppu_arb_pkg;

  // Operator field width; keep in sync with PPU_OP_WIDTH in zeroriscy_defines.
  localparam int PPU_OP_WIDTH = 4;

  localparam logic [31:0] POSIT_NAR = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } ppu_arb_state_e;

endpackage

// File: rtl/ppu_rr_arb2.sv
// Two-input round-robin grant; rr_q selects the winner only when both ports are valid.
module ppu_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_q,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    case (valid)
      2'b01: begin
        grant     = 2'b01;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant     = 2'b10;
        grant_idx = 1'b1;
      end
      2'b11: begin
        grant     = rr_q ? 2'b10 : 2'b01;
        grant_idx = rr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ppu_arbiter.sv
// Shares one PPU between two requesters: accept, issue one-cycle valid, wait with
// a latency bound, then return the result (or NaR + err on timeout) to the winner.
//
// state    | meaning
// ST_IDLE  | no operation; grant a valid requester and latch its operands
// ST_ISSUE | ppu_valid_o high for this single cycle; counter cleared
// ST_WAIT  | waiting for ppu_valid_i, counting toward MAX_LAT
// ST_RESP  | done pulse to the granted port; round-robin pointer flips
module ppu_arbiter
  import ppu_arb_pkg::*;
#(
  parameter int MAX_LAT = 15,
  parameter int OP_W    = PPU_OP_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [31:0]     req0_op_a_i,
  input  logic [31:0]     req0_op_b_i,
  input  logic [OP_W-1:0] req0_op_i,
  output logic            req0_done_o,
  output logic            req0_err_o,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [31:0]     req1_op_a_i,
  input  logic [31:0]     req1_op_b_i,
  input  logic [OP_W-1:0] req1_op_i,
  output logic            req1_done_o,
  output logic            req1_err_o,
  output logic [31:0]     req_result_o,
  output logic            ppu_valid_o,
  output logic [31:0]     ppu_in1_o,
  output logic [31:0]     ppu_in2_o,
  output logic [OP_W-1:0] ppu_op_o,
  input  logic [31:0]     ppu_out_i,
  input  logic            ppu_valid_i,
  output logic            busy_o
);

  localparam logic [7:0] CNT_TC = 8'(MAX_LAT - 1);

  ppu_arb_state_e  state_q, state_d;
  logic            rr_q, rr_d;
  logic            idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     opa_q, opa_d;
  logic [31:0]     opb_q, opb_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [31:0]     result_q, result_d;
  logic            err_q, err_d;

  logic [1:0]      grant;
  logic            grant_idx;
  logic [1:0]      ready;

  ppu_rr_arb2 u_rr (
    .valid     ({req1_valid_i, req0_valid_i}),
    .rr_q      (rr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    ready    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // No accept while reset is held, so no handshake is lost to the reset.
        if (grant != 2'b00 && !rst) begin
          ready   = grant;
          idx_d   = grant_idx;
          opa_d   = grant_idx ? req1_op_a_i : req0_op_a_i;
          opb_d   = grant_idx ? req1_op_b_i : req0_op_b_i;
          op_d    = grant_idx ? req1_op_i   : req0_op_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ppu_valid_i) begin
          result_d = ppu_out_i;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_TC) begin
          result_d = POSIT_NAR;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        rr_d    = ~idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      idx_q    <= 1'b0;
      cnt_q    <= 8'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      op_q     <= '0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign req0_ready_o = ready[0];
  assign req1_ready_o = ready[1];
  assign req0_done_o  = (state_q == ST_RESP) && !idx_q;
  assign req1_done_o  = (state_q == ST_RESP) &&  idx_q;
  assign req0_err_o   = req0_done_o && err_q;
  assign req1_err_o   = req1_done_o && err_q;
  assign req_result_o = result_q;
  assign ppu_valid_o  = (state_q == ST_ISSUE);
  assign ppu_in1_o    = opa_q;
  assign ppu_in2_o    = opb_q;
  assign ppu_op_o     = op_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ppu_arbiter.sv
// Scenario bench for ppu_arbiter with a behavioural PPU of programmable latency.
module tb_ppu_arbiter;
  import ppu_arb_pkg::*;

  localparam int OP_W    = PPU_OP_WIDTH;
  localparam int MAX_LAT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid_i, req0_ready_o, req0_done_o, req0_err_o;
  logic [31:0]     req0_op_a_i, req0_op_b_i;
  logic [OP_W-1:0] req0_op_i;
  logic            req1_valid_i, req1_ready_o, req1_done_o, req1_err_o;
  logic [31:0]     req1_op_a_i, req1_op_b_i;
  logic [OP_W-1:0] req1_op_i;
  logic [31:0]     req_result_o;
  logic            ppu_valid_o;
  logic [31:0]     ppu_in1_o, ppu_in2_o;
  logic [OP_W-1:0] ppu_op_o;
  logic [31:0]     ppu_out_i;
  logic            ppu_valid_i;
  logic            busy_o;

  ppu_arbiter #(.MAX_LAT(MAX_LAT), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_op_a_i(req0_op_a_i), .req0_op_b_i(req0_op_b_i), .req0_op_i(req0_op_i),
    .req0_done_o(req0_done_o), .req0_err_o(req0_err_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_op_a_i(req1_op_a_i), .req1_op_b_i(req1_op_b_i), .req1_op_i(req1_op_i),
    .req1_done_o(req1_done_o), .req1_err_o(req1_err_o),
    .req_result_o(req_result_o), .ppu_valid_o(ppu_valid_o),
    .ppu_in1_o(ppu_in1_o), .ppu_in2_o(ppu_in2_o), .ppu_op_o(ppu_op_o),
    .ppu_out_i(ppu_out_i), .ppu_valid_i(ppu_valid_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          port;
    logic [31:0] result;
    logic        err;
    int          cycle;
  } done_t;

  done_t exp_q[$];
  done_t obs_q[$];
  int    checks = 0;
  int    errors = 0;
  int    both_rdy = 0;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [OP_W-1:0] op);
    return (a ^ {b[15:0], b[31:16]}) + 32'(op);
  endfunction

  // Behavioural PPU: answers ppu_lat cycles after the issue cycle.
  int          ppu_lat = 1;
  bit          ppu_respond = 1'b1;
  bit          stray_req = 1'b0;
  int          cd = 0;
  logic [31:0] pend;
  initial begin
    ppu_valid_i = 1'b0;
    ppu_out_i   = 32'd0;
    forever begin
      @(posedge clk); #1;
      ppu_valid_i = 1'b0;
      if (stray_req) begin
        ppu_valid_i = 1'b1;
        ppu_out_i   = 32'hDEAD_BEEF;
        stray_req   = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ppu_valid_i = 1'b1;
          ppu_out_i   = pend;
        end
      end
      if (ppu_valid_o && ppu_respond) begin
        cd   = ppu_lat;
        pend = model(ppu_in1_o, ppu_in2_o, ppu_op_o);
      end
    end
  end

  // Observer: records done pulses and simultaneous ready strobes.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (req0_ready_o && req1_ready_o) both_rdy++;
      if (req0_done_o) obs_q.push_back('{0, req_result_o, req0_err_o, cyc});
      if (req1_done_o) obs_q.push_back('{1, req_result_o, req1_err_o, cyc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #3;
      if (obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input int port, input logic [31:0] a, input logic [31:0] b,
                      input logic [OP_W-1:0] op, output int acc, output bit ok);
    @(negedge clk);
    if (port == 0) begin
      req0_valid_i = 1'b1; req0_op_a_i = a; req0_op_b_i = b; req0_op_i = op;
    end else begin
      req1_valid_i = 1'b1; req1_op_a_i = a; req1_op_b_i = b; req1_op_i = op;
    end
    #1;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if ((port == 0) ? req0_ready_o : req1_ready_o) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  // Drops the request and scrambles the operands to prove they were latched.
  task automatic release_req(input int port);
    @(negedge clk);
    if (port == 0) begin
      req0_valid_i = 1'b0; req0_op_a_i = 32'hFFFF_FFFF; req0_op_b_i = 32'h0; req0_op_i = '1;
    end else begin
      req1_valid_i = 1'b0; req1_op_a_i = 32'hFFFF_FFFF; req1_op_b_i = 32'h0; req1_op_i = '1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid_i = 1'b0; req0_op_a_i = 32'd0; req0_op_b_i = 32'd0; req0_op_i = '0;
    req1_valid_i = 1'b0; req1_op_a_i = 32'd0; req1_op_b_i = 32'd0; req1_op_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, req0_ready_o, req1_ready_o, req0_done_o, req1_done_o,
         req0_err_o, req1_err_o, ppu_valid_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {busy_o, req0_ready_o, req1_ready_o, req0_done_o, req1_done_o,
                req0_err_o, req1_err_o, ppu_valid_o});
    end
    checks++;
    if ({ppu_in1_o, ppu_in2_o, ppu_op_o} !== '0) begin
      errors++;
      $display("FAIL reset_ppu_data: got in1 %h in2 %h op %h required zeros",
               ppu_in1_o, ppu_in2_o, ppu_op_o);
    end
    checks++;
    if (req_result_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_result: got %h required 00000000", req_result_o);
    end
  endtask

  task automatic test_single();
    int    acc;
    bit    ok;
    done_t e, o;
    ppu_lat = 1;
    send(0, 32'h4000_0000, 32'h4000_0000, 4'd3, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: got no ready required ready0"); end
    exp_q.push_back('{0, model(32'h4000_0000, 32'h4000_0000, 4'd3), 1'b0, acc + 3});
    release_req(0);
    #1;
    checks++;
    if ({ppu_valid_o, ppu_in1_o, ppu_in2_o, ppu_op_o} !== {1'b1, 32'h4000_0000, 32'h4000_0000, 4'd3}) begin
      errors++;
      $display("FAIL single_issue: got v %b in1 %h in2 %h op %h required v 1 in1 40000000 in2 40000000 op 3",
               ppu_valid_o, ppu_in1_o, ppu_in2_o, ppu_op_o);
    end
    @(negedge clk); #1;
    checks++;
    if ({ppu_valid_o, busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL single_issue_width: got valid %b busy %b required valid 0 busy 1", ppu_valid_o, busy_o);
    end
    wait_obs(1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_timeout: got no done required one done"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.port !== e.port || o.err !== e.err || o.result !== e.result || o.cycle !== e.cycle) begin
        errors++;
        $display("FAIL single_done: got port %0d err %b res %h cyc %0d required port %0d err %b res %h cyc %0d",
                 o.port, o.err, o.result, o.cycle, e.port, e.err, e.result, e.cycle);
      end
    end
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (obs_q.size() != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_quiet: got extra dones %0d busy %b required 0 and 0", obs_q.size(), busy_o);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_contention();
    int    order[$];
    int    n;
    int    rdy_base;
    bit    upd0, upd1, ok;
    done_t e, o;
    ppu_lat  = 1;
    n        = 0;
    rdy_base = both_rdy;
    @(negedge clk);
    rst = 1'b1;
    req0_valid_i = 1'b1; req0_op_a_i = 32'h1111_0000; req0_op_b_i = 32'h0000_2222; req0_op_i = 4'd1;
    req1_valid_i = 1'b1; req1_op_a_i = 32'h3333_0000; req1_op_b_i = 32'h0000_4444; req1_op_i = 4'd2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      #1;
      upd0 = 1'b0; upd1 = 1'b0;
      if (req0_ready_o) begin
        order.push_back(0);
        exp_q.push_back('{0, model(req0_op_a_i, req0_op_b_i, req0_op_i), 1'b0, cyc + 3});
        upd0 = 1'b1; n++;
      end else if (req1_ready_o) begin
        order.push_back(1);
        exp_q.push_back('{1, model(req1_op_a_i, req1_op_b_i, req1_op_i), 1'b0, cyc + 3});
        upd1 = 1'b1; n++;
      end
      @(negedge clk);
      if (upd0) begin req0_op_a_i += 32'h0101_0101; req0_op_i += 4'd1; end
      if (upd1) begin req1_op_b_i += 32'h0202_0202; req1_op_i += 4'd3; end
      if (n == 4) begin req0_valid_i = 1'b0; req1_valid_i = 1'b0; end
    end
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL contention_accepts: got %0d accepts required 4", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] != (k % 2)) begin
        errors++;
        $display("FAIL contention_order: op %0d got port %0d required port %0d", k, order[k], k % 2);
      end
    end
    wait_obs(4, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL contention_done_timeout: got %0d dones required 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.port !== e.port || o.err !== e.err || o.result !== e.result || o.cycle !== e.cycle) begin
        errors++;
        $display("FAIL contention_done: got port %0d err %b res %h cyc %0d required port %0d err %b res %h cyc %0d",
                 o.port, o.err, o.result, o.cycle, e.port, e.err, e.result, e.cycle);
      end
    end
    checks++;
    if (both_rdy != rdy_base) begin
      errors++;
      $display("FAIL contention_dual_ready: got %0d cycles with both ready required 0", both_rdy - rdy_base);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    int    acc;
    bit    ok;
    done_t e, o;
    ppu_respond = 1'b0;
    send(1, 32'h1234_5678, 32'h0000_0001, 4'd1, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_accept: got no ready required ready1"); end
    exp_q.push_back('{1, POSIT_NAR, 1'b1, acc + MAX_LAT + 2});
    release_req(1);
    wait_obs(1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_done_timeout: got no done required one done"); end
    @(negedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got busy %b required 0", busy_o);
    end
    // Response on the last WAIT cycle must win over the timeout.
    ppu_respond = 1'b1;
    ppu_lat     = MAX_LAT;
    send(0, 32'h0F0F_0F0F, 32'h1357_9BDF, 4'd5, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_next_accept: got no ready required ready0"); end
    exp_q.push_back('{0, model(32'h0F0F_0F0F, 32'h1357_9BDF, 4'd5), 1'b0, acc + MAX_LAT + 2});
    release_req(0);
    wait_obs(2, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_next_done_timeout: got %0d dones required 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.port !== e.port || o.err !== e.err || o.result !== e.result || o.cycle !== e.cycle) begin
        errors++;
        $display("FAIL timeout_done: got port %0d err %b res %h cyc %0d required port %0d err %b res %h cyc %0d",
                 o.port, o.err, o.result, o.cycle, e.port, e.err, e.result, e.cycle);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stray();
    int          acc;
    bit          ok;
    done_t       e, o;
    logic [31:0] prev;
    ppu_lat = 2;
    prev    = model(32'h0F0F_0F0F, 32'h1357_9BDF, 4'd5);
    @(negedge clk);
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (obs_q.size() != 0 || busy_o !== 1'b0 || req_result_o !== prev) begin
      errors++;
      $display("FAIL stray_idle: got dones %0d busy %b res %h required 0 0 %h",
               obs_q.size(), busy_o, req_result_o, prev);
    end
    send(0, 32'hA5A5_0000, 32'h0000_5A5A, 4'd7, acc, ok);
    stray_req = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL stray_accept: got no ready required ready0"); end
    exp_q.push_back('{0, model(32'hA5A5_0000, 32'h0000_5A5A, 4'd7), 1'b0, acc + 4});
    release_req(0);
    wait_obs(1, 10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stray_done_timeout: got no done required one done"); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.port !== e.port || o.err !== e.err || o.result !== e.result || o.cycle !== e.cycle) begin
        errors++;
        $display("FAIL stray_done: got port %0d err %b res %h cyc %0d required port %0d err %b res %h cyc %0d",
                 o.port, o.err, o.result, o.cycle, e.port, e.err, e.result, e.cycle);
      end
    end
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL stray_extra_done: got %0d extra dones required 0", obs_q.size());
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_wait();
    int acc;
    bit ok;
    ppu_lat = 4;
    send(0, 32'h7777_0000, 32'h0000_8888, 4'd2, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstwait_accept: got no ready required ready0"); end
    release_req(0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, req0_ready_o, req1_ready_o, req0_done_o, req1_done_o,
         req0_err_o, req1_err_o, ppu_valid_o} !== 8'h00) begin
      errors++;
      $display("FAIL rstwait_ctrl: got %b required 00000000",
               {busy_o, req0_ready_o, req1_ready_o, req0_done_o, req1_done_o,
                req0_err_o, req1_err_o, ppu_valid_o});
    end
    checks++;
    if ({ppu_in1_o, ppu_in2_o, ppu_op_o, req_result_o} !== '0) begin
      errors++;
      $display("FAIL rstwait_data: got in1 %h in2 %h op %h res %h required zeros",
               ppu_in1_o, ppu_in2_o, ppu_op_o, req_result_o);
    end
    repeat (8) @(negedge clk);
    #3;
    checks++;
    if (obs_q.size() != 0 || busy_o !== 1'b0 || req_result_o !== 32'd0) begin
      errors++;
      $display("FAIL rstwait_late_resp: got dones %0d busy %b res %h required 0 0 00000000",
               obs_q.size(), busy_o, req_result_o);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int    accs[$];
    int    t0;
    bit    upd, ok;
    done_t e, o;
    ppu_lat = 2;
    t0      = 0;
    @(negedge clk);
    req0_valid_i = 1'b1; req0_op_a_i = 32'h0000_1000; req0_op_b_i = 32'h0003_0000; req0_op_i = 4'd4;
    for (int i = 0; i < 60 && accs.size() < 3; i++) begin
      #1;
      upd = 1'b0;
      if (req0_ready_o) begin
        if (accs.size() == 0) t0 = cyc;
        exp_q.push_back('{0, model(req0_op_a_i, req0_op_b_i, req0_op_i), 1'b0, t0 + 4 + 5 * accs.size()});
        accs.push_back(cyc);
        upd = 1'b1;
      end
      @(negedge clk);
      if (upd) begin req0_op_a_i += 32'h0000_0110; req0_op_b_i ^= 32'h00F0_0000; end
      if (accs.size() == 3) req0_valid_i = 1'b0;
    end
    checks++;
    if (accs.size() != 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d accepts required 3", accs.size());
    end
    for (int k = 1; k < accs.size(); k++) begin
      checks++;
      if (accs[k] - accs[0] != 5 * k) begin
        errors++;
        $display("FAIL b2b_accept_cycle: op %0d got offset %0d required %0d", k, accs[k] - accs[0], 5 * k);
      end
    end
    wait_obs(3, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_done_timeout: got %0d dones required 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.port !== e.port || o.err !== e.err || o.result !== e.result || o.cycle !== e.cycle) begin
        errors++;
        $display("FAIL b2b_done: got port %0d err %b res %h cyc %0d required port %0d err %b res %h cyc %0d",
                 o.port, o.err, o.result, o.cycle, e.port, e.err, e.result, e.cycle);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_stray();
    test_reset_wait();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
